// File: rtl/uart_tx_ctrl_if.sv
// CPU write port and serial-line status of the UART transmit controller.
// The CPU side drives the master modport; the controller takes the slave modport.
interface uart_tx_ctrl_if #(
  parameter int FIFO_DEPTH = 4
);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic             wr_valid;
  logic [7:0]       wr_data;
  logic             wr_ready;
  logic             uart_tx;
  logic             busy;
  logic [CNT_W-1:0] fifo_count;

  modport master (
    output wr_valid,
    output wr_data,
    input  wr_ready,
    input  uart_tx,
    input  busy,
    input  fifo_count
  );

  modport slave (
    input  wr_valid,
    input  wr_data,
    output wr_ready,
    output uart_tx,
    output busy,
    output fifo_count
  );
endinterface

// File: rtl/uart_tx_ctrl.sv
// 8N1 UART transmitter fed by a small byte FIFO. Frames are sent back to back
// while the queue holds data; uart_tx and all status outputs come from registers.
module uart_tx_ctrl #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic          sysclk,
  input  logic          cpu_resetn,
  uart_tx_ctrl_if.slave bus
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  logic [7:0]       r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  state_t           r_state;
  state_t           w_state_next;
  logic [15:0]      r_baud;
  logic [15:0]      w_baud_next;
  logic [2:0]       r_bit;
  logic [2:0]       w_bit_next;
  logic [7:0]       r_shift;
  logic [7:0]       w_shift_next;
  logic             r_tx;
  logic             w_tx_next;

  logic             w_ready;
  logic             w_push;
  logic             w_pop;
  logic             w_have_data;
  logic             w_bit_end;

  // Ready depends only on the registered count, never on wr_valid.
  assign w_ready     = (r_count != CNT_W'(FIFO_DEPTH));
  assign w_push      = bus.wr_valid & w_ready;
  assign w_have_data = (r_count != '0);
  assign w_bit_end   = (r_baud == 16'(CLKS_PER_BIT - 1));

  always_comb begin
    w_state_next = r_state;
    w_baud_next  = r_baud + 16'd1;
    w_bit_next   = r_bit;
    w_shift_next = r_shift;
    w_tx_next    = r_tx;
    w_pop        = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_baud_next = '0;
        w_tx_next   = 1'b1;
        if (w_have_data) begin
          w_pop        = 1'b1;
          w_state_next = S_START;
          w_tx_next    = 1'b0;
          w_shift_next = r_mem[r_rd_ptr];
        end
      end
      S_START: begin
        if (w_bit_end) begin
          w_baud_next  = '0;
          w_bit_next   = '0;
          w_state_next = S_DATA;
          w_tx_next    = r_shift[0];
          w_shift_next = {1'b0, r_shift[7:1]};
        end
      end
      S_DATA: begin
        if (w_bit_end) begin
          w_baud_next = '0;
          if (r_bit == 3'd7) begin
            w_state_next = S_STOP;
            w_tx_next    = 1'b1;
          end else begin
            w_bit_next   = r_bit + 3'd1;
            w_tx_next    = r_shift[0];
            w_shift_next = {1'b0, r_shift[7:1]};
          end
        end
      end
      S_STOP: begin
        if (w_bit_end) begin
          w_baud_next = '0;
          // Chain straight into the next start bit so frames have no idle gap.
          if (w_have_data) begin
            w_pop        = 1'b1;
            w_state_next = S_START;
            w_tx_next    = 1'b0;
            w_shift_next = r_mem[r_rd_ptr];
          end else begin
            w_state_next = S_IDLE;
            w_tx_next    = 1'b1;
          end
        end
      end
      default: begin
        w_state_next = S_IDLE;
        w_baud_next  = '0;
        w_tx_next    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge sysclk or negedge cpu_resetn) begin
    if (!cpu_resetn) begin
      r_state <= S_IDLE;
      r_baud  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_tx    <= 1'b1;
    end else begin
      r_state <= w_state_next;
      r_baud  <= w_baud_next;
      r_bit   <= w_bit_next;
      r_shift <= w_shift_next;
      r_tx    <= w_tx_next;
    end
  end

  always_ff @(posedge sysclk or negedge cpu_resetn) begin
    if (!cpu_resetn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage is left unreset so it maps onto plain RAM.
  always_ff @(posedge sysclk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= bus.wr_data;
    end
  end

  assign bus.wr_ready   = w_ready;
  assign bus.uart_tx    = r_tx;
  assign bus.busy       = (r_state != S_IDLE) || w_have_data;
  assign bus.fifo_count = r_count;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Randomized and directed bench for uart_tx_ctrl: accepted bytes go to a scoreboard
// queue, and a line monitor decodes every frame and checks it against the queue head.
module tb_uart_tx_ctrl;
  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  localparam int FRAME = 10 * CPB;

  logic sysclk     = 1'b0;
  logic cpu_resetn = 1'b1;
  always #5 sysclk = ~sysclk;

  uart_tx_ctrl_if #(.FIFO_DEPTH(DEPTH)) bus ();

  uart_tx_ctrl #(
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .sysclk    (sysclk),
    .cpu_resetn(cpu_resetn),
    .bus       (bus)
  );

  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_q[$];
  int         start_q[$];
  int         acc_count = 0;
  int         frames_started = 0;
  int         cyc = 0;
  int         last_acc_cyc = 0;
  int         low_samples = 0;
  bit         in_frame = 0;
  bit         expect_start = 0;
  int         pos = 0;
  int         bad = 0;
  logic [9:0] pattern = '1;
  logic [7:0] cur_byte = '0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, got, exp);
    end
  endtask

  always @(posedge sysclk) cyc <= cyc + 1;

  // Line monitor plus per-cycle model of the queue occupancy.
  always @(posedge sysclk) begin
    #1;
    if (!cpu_resetn) begin
      in_frame       = 0;
      expect_start   = 0;
      frames_started = 0;
    end else begin
      int mc;
      if (expect_start) begin
        check("gapless_start", bus.uart_tx, 0);
        expect_start = 0;
      end
      if (!in_frame && bus.uart_tx == 1'b0) begin
        in_frame = 1;
        pos      = 0;
        bad      = 0;
        frames_started++;
        start_q.push_back(cyc);
        check("frame_was_expected", exp_q.size() > 0, 1);
        cur_byte = (exp_q.size() > 0) ? exp_q.pop_front() : 8'h00;
        pattern  = {1'b1, cur_byte, 1'b0};
      end
      mc = acc_count - frames_started;
      check("fifo_count", bus.fifo_count, mc);
      check("wr_ready", bus.wr_ready, mc != DEPTH);
      check("busy", bus.busy, in_frame || mc != 0);
      if (!bus.uart_tx) low_samples++;
      if (in_frame) begin
        if (bus.uart_tx !== pattern[pos / CPB]) bad++;
        pos++;
        if (pos == FRAME) begin
          check($sformatf("frame_0x%02h_bad_samples", cur_byte), bad, 0);
          in_frame = 0;
          if (mc > 0) expect_start = 1;
        end
      end
    end
  end

  // Called just after a falling edge; records a byte the DUT will accept on the next rise.
  task automatic put(input logic v, input logic [7:0] d, output bit ok);
    bus.wr_valid = v;
    bus.wr_data  = d;
    ok = v && bus.wr_ready;
    if (ok) begin
      exp_q.push_back(d);
      acc_count++;
      last_acc_cyc = cyc + 1;
    end
  endtask

  task automatic write_wait(input logic [7:0] d);
    bit ok = 0;
    for (int t = 0; t < 400 && !ok; t++) begin
      @(negedge sysclk);
      put(1'b1, d, ok);
    end
    if (!ok) check("write_timeout", 0, 1);
  endtask

  task automatic release_bus();
    bit ok;
    @(negedge sysclk);
    put(1'b0, 8'h00, ok);
  endtask

  task automatic wait_frames(input int n, input int budget);
    for (int t = 0; t < budget && start_q.size() < n; t++) @(negedge sysclk);
    if (start_q.size() < n) check("frame_start_timeout", start_q.size(), n);
  endtask

  task automatic wait_idle(input int budget);
    for (int t = 0; t < budget && bus.busy !== 1'b0; t++) @(negedge sysclk);
    if (bus.busy !== 1'b0) check("idle_timeout", bus.busy, 0);
  endtask

  initial begin
    int  base;
    int  acc0;
    int  low0;
    bit  ok;
    bus.wr_valid = 1'b0;
    bus.wr_data  = 8'h00;
    #1 cpu_resetn = 1'b0;
    #2;
    check("reset_uart_tx", bus.uart_tx, 1);
    check("reset_busy", bus.busy, 0);
    check("reset_wr_ready", bus.wr_ready, 1);
    check("reset_fifo_count", bus.fifo_count, 0);
    repeat (3) @(negedge sysclk);
    cpu_resetn = 1'b1;
    repeat (2) @(negedge sysclk);

    // Single byte into an idle queue: start bit one edge after acceptance.
    base = start_q.size();
    write_wait(8'h55);
    release_bus();
    wait_frames(base + 1, 20);
    wait_idle(100);
    if (start_q.size() > base) begin
      check("latency_0x55", start_q[base] - last_acc_cyc, 1);
      check("busy_fall_0x55", cyc - start_q[base], FRAME);
    end

    // Two consecutive writes go out back to back.
    base = start_q.size();
    write_wait(8'hA3);
    write_wait(8'h0F);
    release_bus();
    wait_frames(base + 2, 200);
    if (start_q.size() > base + 1)
      check("second_start_offset", start_q[base + 1] - start_q[base], FRAME);
    wait_idle(200);

    // Six distinct bytes on six edges: five fit (one pops immediately), the sixth is refused.
    base = start_q.size();
    acc0 = acc_count;
    for (int i = 0; i < 6; i++) begin
      @(negedge sysclk);
      put(1'b1, 8'h60 + 8'(i * 7), ok);
    end
    @(negedge sysclk);
    check("accepted_of_six", acc_count - acc0, 5);
    check("full_fifo_count", bus.fifo_count, DEPTH);
    check("full_wr_ready", bus.wr_ready, 0);
    // Keep offering until space opens at the end of the first frame.
    put(1'b1, 8'hC6, ok);
    for (int t = 0; t < 200 && !ok; t++) begin
      @(negedge sysclk);
      put(1'b1, 8'hC6, ok);
    end
    check("held_write_accepted", ok, 1);
    @(negedge sysclk);
    put(1'b0, 8'h00, ok);
    check("refill_fifo_count", bus.fifo_count, DEPTH);
    if (start_q.size() > base + 1)
      check("accept_when_ready_rises", last_acc_cyc - start_q[base + 1], 1);
    wait_idle(400);

    // Random traffic with frequent full-queue and push/pop coincidences.
    for (int t = 0; t < 3000; t++) begin
      @(negedge sysclk);
      put($urandom_range(0, 15) == 0, 8'($urandom), ok);
    end
    release_bus();
    wait_idle(400);
    check("scoreboard_drained", exp_q.size(), 0);

    // Reset in the middle of the second of three queued frames.
    base = start_q.size();
    write_wait(8'h11);
    write_wait(8'h22);
    write_wait(8'h33);
    release_bus();
    wait_frames(base + 2, 200);
    repeat (8) @(negedge sysclk);
    #2 cpu_resetn = 1'b0;
    #1;
    check("abort_uart_tx", bus.uart_tx, 1);
    check("abort_fifo_count", bus.fifo_count, 0);
    check("abort_busy", bus.busy, 0);
    check("abort_wr_ready", bus.wr_ready, 1);
    exp_q.delete();
    acc_count = 0;
    repeat (3) @(negedge sysclk);
    cpu_resetn = 1'b1;
    base = start_q.size();
    repeat (100) @(negedge sysclk);
    check("no_frames_after_reset", start_q.size(), base);

    // First write after reset behaves like a fresh idle write.
    base = start_q.size();
    write_wait(8'h3C);
    release_bus();
    wait_frames(base + 1, 20);
    if (start_q.size() > base)
      check("latency_after_reset", start_q[base] - last_acc_cyc, 1);
    wait_idle(100);

    // Long idle stretch with no writes.
    low0 = low_samples;
    repeat (1000) @(negedge sysclk);
    check("idle_line_low_samples", low_samples - low0, 0);
    check("idle_uart_tx", bus.uart_tx, 1);
    check("idle_busy", bus.busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
